// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush generator for the IF..MEM pipeline registers (load-use, divide, bus wait, branch, exception).
// Optional performance counters are enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int DIV_LAT = 36,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id2_rs,
  input  logic [4:0]  id2_rt,
  input  logic        id2_use_rs,
  input  logic        id2_use_rt,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_w_reg_dst,
  input  logic        ex_is_div,
  input  logic        ex_branch_taken,
  input  logic        mem_wait,
  input  logic        exc_commit,
  output logic        stall_pc,
  output logic        stall_if_id,
  output logic        stall_id_id2,
  output logic        stall_id2_ex,
  output logic        stall_ex_mem,
  output logic        flush_if_id,
  output logic        flush_id_id2,
  output logic        flush_id2_ex,
  output logic        flush_ex_mem,
  output logic        exception_flush,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
`endif
  output logic        div_busy
);

  typedef enum logic [1:0] {IDLE, DIV_BUSY, DIV_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             load_use;
  logic             div_stall;

  assign cnt_nxt = cnt + CNT_W'(1);

  // Divide occupancy tracker; counts on through mem_wait, aborted by exc_commit.
  always_ff @(posedge clk) begin
    if (rst || exc_commit) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_is_div && !mem_wait) begin
            state <= (CNT_LAST == CNT_W'(1)) ? DIV_DONE : DIV_BUSY;
            cnt   <= CNT_W'(1);
          end
        end
        DIV_BUSY: begin
          cnt <= cnt_nxt;
          if (cnt_nxt == CNT_LAST) state <= DIV_DONE;
        end
        DIV_DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign load_use = ex_is_load && (ex_w_reg_dst != 5'd0) &&
                    ((id2_use_rs && (id2_rs == ex_w_reg_dst)) ||
                     (id2_use_rt && (id2_rt == ex_w_reg_dst)));

  assign div_stall = (state == DIV_BUSY) || ((state == IDLE) && ex_is_div);

  always_comb begin
    stall_pc        = 1'b0;
    stall_if_id     = 1'b0;
    stall_id_id2    = 1'b0;
    stall_id2_ex    = 1'b0;
    stall_ex_mem    = 1'b0;
    flush_if_id     = 1'b0;
    flush_id_id2    = 1'b0;
    flush_id2_ex    = 1'b0;
    flush_ex_mem    = 1'b0;
    exception_flush = 1'b0;
    div_busy        = (state == DIV_BUSY) && !rst;
    if (rst) begin
      stall_pc = 1'b0;
    end else if (exc_commit) begin
      exception_flush = 1'b1;
    end else if (mem_wait) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_id2 = 1'b1;
      stall_id2_ex = 1'b1;
      stall_ex_mem = 1'b1;
    end else if (div_stall) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_id2 = 1'b1;
      stall_id2_ex = 1'b1;
      flush_ex_mem = 1'b1;
    end else if (load_use) begin
      // One bubble behind the load; forwarding from MEM covers the rest.
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      stall_id_id2 = 1'b1;
      flush_id2_ex = 1'b1;
    end else if (ex_branch_taken) begin
      flush_if_id  = 1'b1;
      flush_id_id2 = 1'b1;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_pc)        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (exception_flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl; perf counter checks are active when PIPE_HAZARD_PERF_EN is defined.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id2_rs, id2_rt, ex_w_reg_dst;
  logic       id2_use_rs, id2_use_rt, ex_is_load, ex_is_div;
  logic       ex_branch_taken, mem_wait, exc_commit;
  logic       stall_pc, stall_if_id, stall_id_id2, stall_id2_ex, stall_ex_mem;
  logic       flush_if_id, flush_id_id2, flush_id2_ex, flush_ex_mem;
  logic       exception_flush, div_busy;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  // {stall_pc,if_id,id_id2,id2_ex,ex_mem, flush_if_id,id_id2,id2_ex,ex_mem, exception_flush}
  localparam logic [9:0] O_NONE = 10'b00000_00000;
  localparam logic [9:0] O_LU   = 10'b11100_00100;
  localparam logic [9:0] O_DIV  = 10'b11110_00010;
  localparam logic [9:0] O_MEMW = 10'b11111_00000;
  localparam logic [9:0] O_BR   = 10'b00000_11000;
  localparam logic [9:0] O_EXC  = 10'b00000_00001;

  pipe_hazard_ctrl #(.DIV_LAT(36), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .id2_rs(id2_rs), .id2_rt(id2_rt), .id2_use_rs(id2_use_rs), .id2_use_rt(id2_use_rt),
    .ex_is_load(ex_is_load), .ex_w_reg_dst(ex_w_reg_dst), .ex_is_div(ex_is_div),
    .ex_branch_taken(ex_branch_taken), .mem_wait(mem_wait), .exc_commit(exc_commit),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_id2(stall_id_id2),
    .stall_id2_ex(stall_id2_ex), .stall_ex_mem(stall_ex_mem),
    .flush_if_id(flush_if_id), .flush_id_id2(flush_id_id2), .flush_id2_ex(flush_id2_ex),
    .flush_ex_mem(flush_ex_mem), .exception_flush(exception_flush),
`ifdef PIPE_HAZARD_PERF_EN
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [9:0] outs();
    return {stall_pc, stall_if_id, stall_id_id2, stall_id2_ex, stall_ex_mem,
            flush_if_id, flush_id_id2, flush_id2_ex, flush_ex_mem, exception_flush};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id2_rs = 5'd0; id2_rt = 5'd0; id2_use_rs = 1'b0; id2_use_rt = 1'b0;
    ex_is_load = 1'b0; ex_w_reg_dst = 5'd0; ex_is_div = 1'b0;
    ex_branch_taken = 1'b0; mem_wait = 1'b0; exc_commit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    ex_is_div = 1'b1; ex_is_load = 1'b1; ex_w_reg_dst = 5'd5; id2_rs = 5'd5; id2_use_rs = 1'b1;
    tick(); tick();
    total_cnt++;
    if (outs() !== O_NONE) $display("FAIL reset_outs: got %b want %b", outs(), O_NONE);
    else pass_cnt++;
    total_cnt++;
    if (div_busy !== 1'b0) $display("FAIL reset_div_busy: got %b want 0", div_busy);
    else pass_cnt++;
    rst = 1'b0;
    clear_inputs();
    #1;
    total_cnt++;
    if (outs() !== O_NONE || div_busy !== 1'b0)
      $display("FAIL post_reset: got %b/%b want %b/0", outs(), div_busy, O_NONE);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_load_use();
    ex_is_load = 1'b1; ex_w_reg_dst = 5'd5; id2_rs = 5'd5; id2_use_rs = 1'b1;
    #1;
    total_cnt++;
    if (outs() !== O_LU) $display("FAIL load_use_rs: got %b want %b", outs(), O_LU);
    else pass_cnt++;
    tick();
    clear_inputs();
    ex_is_load = 1'b1; ex_w_reg_dst = 5'd9; id2_rt = 5'd9; id2_use_rt = 1'b1; id2_rs = 5'd3; id2_use_rs = 1'b1;
    #1;
    total_cnt++;
    if (outs() !== O_LU) $display("FAIL load_use_rt: got %b want %b", outs(), O_LU);
    else pass_cnt++;
    tick();
    clear_inputs();
    // load-use beats a taken branch in the same cycle
    ex_is_load = 1'b1; ex_w_reg_dst = 5'd7; id2_rs = 5'd7; id2_use_rs = 1'b1; ex_branch_taken = 1'b1;
    #1;
    total_cnt++;
    if (outs() !== O_LU) $display("FAIL load_use_vs_branch: got %b want %b", outs(), O_LU);
    else pass_cnt++;
    tick();
    clear_inputs();
  endtask

  task automatic test_load_use_neg();
    ex_is_load = 1'b1; ex_w_reg_dst = 5'd0; id2_rs = 5'd0; id2_use_rs = 1'b1;
    #1;
    total_cnt++;
    if (outs() !== O_NONE) $display("FAIL load_use_r0: got %b want %b", outs(), O_NONE);
    else pass_cnt++;
    tick();
    ex_w_reg_dst = 5'd5; id2_rs = 5'd5; id2_use_rs = 1'b0;
    #1;
    total_cnt++;
    if (outs() !== O_NONE) $display("FAIL load_use_unused: got %b want %b", outs(), O_NONE);
    else pass_cnt++;
    tick();
    clear_inputs();
  endtask

  task automatic test_branch();
    ex_branch_taken = 1'b1;
    #1;
    total_cnt++;
    if (outs() !== O_BR) $display("FAIL branch: got %b want %b", outs(), O_BR);
    else pass_cnt++;
    tick();
    clear_inputs();
  endtask

  task automatic test_div();
    int st = 0;
    int bz = 0;
    ex_is_div = 1'b1;
    for (int i = 0; i < 35; i++) begin
      #1;
      if (outs() === O_DIV) st++;
      if (div_busy === 1'b1) bz++;
      tick();
    end
    #1;
    total_cnt++;
    if (outs() !== O_NONE || div_busy !== 1'b0)
      $display("FAIL div_done_free: got %b/%b want %b/0", outs(), div_busy, O_NONE);
    else pass_cnt++;
    ex_is_div = 1'b0;
    total_cnt++;
    if (st !== 35) $display("FAIL div_stall_cycles: got %0d want 35", st);
    else pass_cnt++;
    total_cnt++;
    if (bz !== 34) $display("FAIL div_busy_cycles: got %0d want 34", bz);
    else pass_cnt++;
    tick();
    #1;
    total_cnt++;
    if (outs() !== O_NONE) $display("FAIL div_after: got %b want %b", outs(), O_NONE);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_exc_div();
    int st = 0;
    ex_is_div = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (outs() === O_DIV) st++;
      tick();
    end
    total_cnt++;
    if (st !== 10) $display("FAIL exc_div_pre_stalls: got %0d want 10", st);
    else pass_cnt++;
    exc_commit = 1'b1; ex_is_div = 1'b0;
    #1;
    total_cnt++;
    if (outs() !== O_EXC) $display("FAIL exc_flush: got %b want %b", outs(), O_EXC);
    else pass_cnt++;
    tick();
    exc_commit = 1'b0;
    #1;
    total_cnt++;
    if (div_busy !== 1'b0 || outs() !== O_NONE)
      $display("FAIL exc_after: got %b/%b want %b/0", outs(), div_busy, O_NONE);
    else pass_cnt++;
    tick();
    #1;
    total_cnt++;
    if (outs() !== O_NONE) $display("FAIL exc_after2: got %b want %b", outs(), O_NONE);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_mem_wait_branch();
    mem_wait = 1'b1; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if (outs() !== O_MEMW) $display("FAIL mem_wait_c%0d: got %b want %b", i, outs(), O_MEMW);
      else pass_cnt++;
      tick();
    end
    mem_wait = 1'b0;
    #1;
    total_cnt++;
    if (outs() !== O_BR) $display("FAIL mem_wait_branch_after: got %b want %b", outs(), O_BR);
    else pass_cnt++;
    tick();
    clear_inputs();
  endtask

  task automatic test_mem_wait_div_issue();
    ex_is_div = 1'b1; mem_wait = 1'b1;
    #1;
    total_cnt++;
    if (outs() !== O_MEMW) $display("FAIL memw_div_prio: got %b want %b", outs(), O_MEMW);
    else pass_cnt++;
    tick();
    clear_inputs();
    #1;
    total_cnt++;
    if (div_busy !== 1'b0 || outs() !== O_NONE)
      $display("FAIL memw_div_no_issue: got %b/%b want %b/0", outs(), div_busy, O_NONE);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_rst_mid_div();
    ex_is_div = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    ex_is_div = 1'b0;
    #1;
    total_cnt++;
    if (div_busy !== 1'b1) $display("FAIL mid_div_busy: got %b want 1", div_busy);
    else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (outs() !== O_NONE || div_busy !== 1'b0)
      $display("FAIL rst_mid_div: got %b/%b want %b/0", outs(), div_busy, O_NONE);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    #1;
    total_cnt++;
    if (outs() !== O_NONE || div_busy !== 1'b0)
      $display("FAIL rst_mid_div_after: got %b/%b want %b/0", outs(), div_busy, O_NONE);
    else pass_cnt++;
    tick();
  endtask

`ifdef PIPE_HAZARD_PERF_EN
  task automatic test_perf();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
    ex_is_load = 1'b1; ex_w_reg_dst = 5'd5; id2_rs = 5'd5; id2_use_rs = 1'b1;
    tick();
    clear_inputs();
    ex_is_div = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    exc_commit = 1'b1; ex_is_div = 1'b0;
    tick();
    exc_commit = 1'b0;
    tick();
    total_cnt++;
    if (perf_stall_cnt !== 32'd11) $display("FAIL perf_stall_cnt: got %0d want 11", perf_stall_cnt);
    else pass_cnt++;
    total_cnt++;
    if (perf_flush_cnt !== 32'd1) $display("FAIL perf_flush_cnt: got %0d want 1", perf_flush_cnt);
    else pass_cnt++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_load_use_neg();
    test_branch();
    test_div();
    test_exc_div();
    test_mem_wait_branch();
    test_mem_wait_div_issue();
    test_rst_mid_div();
`ifdef PIPE_HAZARD_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
